// File: rtl/mat_rd_arbiter.sv
// mat_rd_arbiter
//   Shares one synchronous-read matrix memory port between two matrix-builder
//   engines (e.g. a Hankel and a Toeplitz builder). Whole bursts are granted
//   round-robin. Each grant accepts at most MAX_BURST reads before the arbiter
//   is forced to re-arbitrate. Read data is steered back to the issuing engine
//   by a {valid, id} tag pipeline that is as deep as the memory read latency.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req0/req1           engine wants the port; held high for the whole burst
//   rd0/rd1             engine read strobe (ignored unless granted)
//   addr0/addr1         engine read address
//   gnt0/gnt1           engine owns the port (decoded from registered state)
//   data0/data1         read data (memory data broadcast to both engines)
//   vld0/vld1           data valid for that engine
//   mem_rd, mem_addr    memory read strobe / address
//   mem_data            memory read data, valid RD_LAT cycles after mem_rd

module mat_rd_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 16,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          rd0,
  input  logic [AW-1:0] addr0,
  output logic          gnt0,
  output logic [DW-1:0] data0,
  output logic          vld0,
  input  logic          req1,
  input  logic          rd1,
  input  logic [AW-1:0] addr1,
  output logic          gnt1,
  output logic [DW-1:0] data1,
  output logic          vld1,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            ptr;        // 0: requester 0 wins a tie, 1: requester 1 wins
  logic [CW-1:0]   cnt;        // reads accepted in the current grant
  logic            accept;
  logic            burst_hit;  // this accept completes a full burst
  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0] pipe_id;

  // Grants come straight from the state register, so rd/addr never reach them.
  assign gnt0 = (state == G0);
  assign gnt1 = (state == G1);

  assign accept    = (gnt0 && rd0) || (gnt1 && rd1);
  assign burst_hit = accept && (cnt == CW'(MAX_BURST - 1));

  assign mem_rd   = accept;
  assign mem_addr = gnt0 ? addr0 : (gnt1 ? addr1 : '0);

  // Memory data is broadcast; the tag at the end of the pipe says whose it is.
  assign data0 = mem_data;
  assign data1 = mem_data;
  assign vld0  = pipe_vld[RD_LAT-1] && !pipe_id[RD_LAT-1];
  assign vld1  = pipe_vld[RD_LAT-1] &&  pipe_id[RD_LAT-1];

  // Release (req low) takes priority over the burst limit. At the limit with
  // no competing request the state holds and only the counter restarts.
  always_comb begin
    // NOTE: next state defaults to the current state so no path leaves it unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req0 && req1) state_nxt = ptr ? G1 : G0;
        else if (req0)    state_nxt = G0;
        else if (req1)    state_nxt = G1;
      end
      G0: begin
        if (!req0)                  state_nxt = req1 ? G1 : IDLE;
        else if (burst_hit && req1) state_nxt = G1;
      end
      G1: begin
        if (!req1)                  state_nxt = req0 ? G0 : IDLE;
        else if (burst_hit && req0) state_nxt = G0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the tag pipeline is cleared on reset so reads in flight never produce a vld.
      state    <= IDLE;
      ptr      <= 1'b0;
      cnt      <= '0;
      pipe_vld <= '0;
      pipe_id  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;

      // Entering a grant hands the next tie to the other requester.
      if (state_nxt == G0 && state != G0)      ptr <= 1'b1;
      else if (state_nxt == G1 && state != G1) ptr <= 1'b0;

      if (state_nxt != state || burst_hit) cnt <= '0;
      else if (accept)                     cnt <= cnt + CW'(1);

      pipe_vld[0] <= accept;
      pipe_id[0]  <= gnt1;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
      end
    end
  end

endmodule

// File: doc/mat_rd_arbiter.md
Name: mat_rd_arbiter

Overview:
- Shares one synchronous-read matrix memory port (8-bit address, 16-bit data) between two matrix-builder engines, e.g. a Hankel builder and a Toeplitz builder.
- Each engine keeps its own rd/addr/data interface; the arbiter grants whole bursts, round-robin.
- Burst length is capped for fairness.
- Read data is routed back to the issuing requester through a tag pipeline matched to the memory read latency.

Parameters:
AW, 8, address width
DW, 16, data width
RD_LAT, 1, memory read latency in cycles (mem_data valid RD_LAT cycles after mem_rd); legal range 1..4
MAX_BURST, 64, maximum reads accepted per grant before forced re-arbitration

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req0  in  1  requester 0 wants the port; held high for the whole burst
rd0  in  1  requester 0 read strobe
addr0  in  AW  requester 0 read address
gnt0  out  1  requester 0 owns the port (registered)
data0  out  DW  read data to requester 0
vld0  out  1  data0 valid
req1, rd1, addr1, gnt1, data1, vld1: same as requester 0, for requester 1
mem_rd  out  1  memory read strobe
mem_addr  out  AW  memory address
mem_data  in  DW  memory read data

Behaviour:
- Reset (asynchronous, any time, including mid-burst):
  - gnt0 = gnt1 = 0, mem_rd = 0, mem_addr = 0, vld0 = vld1 = 0.
  - Tag pipeline cleared; burst counter = 0; round-robin pointer favours requester 0; state IDLE.
  - Reads in flight at reset are discarded; no vld is produced for them.
- States:
  - IDLE: no grant.
  - G0: gnt0 = 1.
  - G1: gnt1 = 1.
  - gnt0/gnt1 are decoded from registered state; they are never both high.
- IDLE transitions:
  - Only req0 sampled high -> G0. Only req1 -> G1. Neither -> stay IDLE.
  - Both high -> requester favoured by the pointer. After reset that is 0; afterwards it is the requester not granted most recently.
  - Grant appears the cycle after req is sampled: req at edge T gives gnt at T+1.
- Accept: read accepted in a cycle when gntN && rdN.
  - mem_rd = accept (combinational); mem_addr = addrN of the granted requester, else 0.
  - rdN without gntN is ignored: no memory access, no vld.
- Burst counter:
  - Increments on each accept; resets to 0 on every grant change and on re-grant.
  - Width clog2(MAX_BURST+1).
- Release in GN:
  - reqN sampled low -> gnt drops next cycle. The state then goes to the other requester if its req is high, else IDLE; no idle bubble when switching.
  - A read accepted in the last granted cycle is still serviced.
- Burst limit: when an accept makes the count reach MAX_BURST:
  - If the other req is high -> switch to the other requester next cycle.
  - Else -> stay granted; counter resets to 0; gnt stays high with no gap.
  - If reqN is low in that same cycle, the release rule wins.
- Pointer update: on every transition into G0/G1, the pointer is set to favour the other requester.
- Return path:
  - RD_LAT-deep shift register of {valid, id}; entry pushed on accept with id = granted requester.
  - data0 = data1 = mem_data (broadcast).
  - vldN = pipe output valid && id == N, aligned with mem_data.
  - Reads in flight across a grant switch return to the original requester, in order.
- Throughput: one read per cycle while granted. Switching costs no dead cycle on the memory port beyond the registered-grant cycle.
- No combinational path from rdN/addrN to gnt*.

Test Plan:
1. Reset, then req0 = 1 at edge 0 and rd0 = 1 with addr0 = 0..7 from first gnt0 cycle:
   - gnt0 = 1 from edge 1.
   - mem_addr = 0..7 consecutively.
   - vld0 pulses 8 cycles, 1 cycle after each accept (RD_LAT = 1), with data0 = memory contents 0..7.
   - vld1 stays 0.
2. req0 and req1 rise on the same edge after reset:
   - gnt0 first.
   - req0 drops after 4 reads -> gnt1 the next cycle with no IDLE cycle.
   - The final read of requester 0 returns on vld0 while gnt1 = 1.
3. Both requesters hold req with rd continuous, MAX_BURST = 64:
   - Grants alternate every 64 accepts: 0, 1, 0, ...
   - Each requester gets exactly 64 vld pulses per turn.
4. Only req1 held with rd continuous for 150 reads:
   - gnt1 stays high throughout with no gap at reads 64 and 128.
   - 150 vld1 pulses.
5. rd1 = 1, addr1 = 8'h55 while req1 = 0 and gnt0 = 1:
   - mem_addr never shows 8'h55.
   - No vld1.
6. Assert rst for 1 cycle mid-burst with 1 read in flight:
   - gnt0, mem_rd, vld0 and vld1 go 0 immediately.
   - No vld pulse for the in-flight read.
   - After release with both req high, gnt0 is granted first.
